// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        HALTED
    } mem_state_t;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 15;

endpackage

// File: rtl/mem_if.sv
// Data-memory request/acknowledge bus between the memory stage and the memory.
interface mem_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/mem_timeout_ctr.sv
// Counts cycles while enabled; expired is high during the LIMIT-th enabled cycle.
module mem_timeout_ctr
    import mem_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count;

    assign expired = enable && (count == W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_unit.sv
// Pipeline memory stage: holds one EX instruction, performs its data access, retires it.
// Optional access timeout is enabled with the MEM_TIMEOUT_EN macro.
module mem_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic        RegWrite_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        mem_to_reg_in,
    input  logic        ret_future_in,
    input  logic        HALT_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result,
    input  logic [15:0] sw_data,
    output logic        mem_stall,
    mem_if.master       dmem,
    output logic        out_valid,
    output logic        RegWrite_out,
    output logic        mem_to_reg_out,
    output logic        ret_future_out,
    output logic        HALT_out,
    output logic [3:0]  reg_rd_out,
    output logic [15:0] alu_result_out,
    output logic [15:0] mem_data_out,
    output logic        mem_err
);

    mem_state_t  state, next_state;

    logic        h_regwrite, h_memwrite, h_memread, h_mem_to_reg, h_ret_future, h_halt;
    logic [3:0]  h_rd;
    logic [15:0] h_alu, h_sw;

    logic        accept, in_is_mem, in_access, acked, timed_out;

    assign in_access = (state == ACCESS);
    assign mem_stall = (state != IDLE);
    assign accept    = (state == IDLE) && in_valid;
    assign in_is_mem = MemRead_in || MemWrite_in;
    assign acked     = in_access && dmem.dmem_ack;

    assign dmem.dmem_req   = in_access;
    assign dmem.dmem_we    = h_memwrite;
    assign dmem.dmem_addr  = h_alu;
    assign dmem.dmem_wdata = h_sw;

`ifdef MEM_TIMEOUT_EN
    logic expired;

    mem_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!in_access),
        .enable  (in_access),
        .expired (expired)
    );

    // An ack in the limit cycle completes the access normally.
    assign timed_out = expired && !dmem.dmem_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else if (timed_out) begin
            mem_err <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_is_mem)    next_state = ACCESS;
                    else if (HALT_in) next_state = HALTED;
                end
            end
            ACCESS: begin
                if (acked || timed_out) next_state = h_halt ? HALTED : IDLE;
            end
            HALTED:  next_state = HALTED;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_regwrite     <= 1'b0;
            h_memwrite     <= 1'b0;
            h_memread      <= 1'b0;
            h_mem_to_reg   <= 1'b0;
            h_ret_future   <= 1'b0;
            h_halt         <= 1'b0;
            h_rd           <= '0;
            h_alu          <= '0;
            h_sw           <= '0;
            out_valid      <= 1'b0;
            RegWrite_out   <= 1'b0;
            mem_to_reg_out <= 1'b0;
            ret_future_out <= 1'b0;
            HALT_out       <= 1'b0;
            reg_rd_out     <= '0;
            alu_result_out <= '0;
            mem_data_out   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                h_regwrite   <= RegWrite_in;
                h_memwrite   <= MemWrite_in;
                h_memread    <= MemRead_in;
                h_mem_to_reg <= mem_to_reg_in;
                h_ret_future <= ret_future_in;
                h_halt       <= HALT_in;
                h_rd         <= reg_rd_in;
                h_alu        <= alu_result;
                h_sw         <= sw_data;
                // Non-memory ops retire straight from the inputs, bypassing the holding regs.
                if (!in_is_mem) begin
                    out_valid      <= 1'b1;
                    RegWrite_out   <= RegWrite_in;
                    mem_to_reg_out <= mem_to_reg_in;
                    ret_future_out <= ret_future_in;
                    HALT_out       <= HALT_in;
                    reg_rd_out     <= reg_rd_in;
                    alu_result_out <= alu_result;
                end
            end
            if (acked || timed_out) begin
                out_valid      <= 1'b1;
                RegWrite_out   <= h_regwrite && !timed_out;
                mem_to_reg_out <= h_mem_to_reg;
                ret_future_out <= h_ret_future;
                HALT_out       <= h_halt;
                reg_rd_out     <= h_rd;
                alu_result_out <= h_alu;
                if (acked && h_memread && !h_memwrite) begin
                    mem_data_out <= dmem.dmem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_unit.sv
// Directed self-checking bench for mem_unit; timeout scenarios run when MEM_TIMEOUT_EN is defined.
module tb_mem_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        RegWrite_in = 1'b0, MemWrite_in = 1'b0, MemRead_in = 1'b0;
    logic        mem_to_reg_in = 1'b0, ret_future_in = 1'b0, HALT_in = 1'b0;
    logic [3:0]  reg_rd_in = '0;
    logic [15:0] alu_result = '0, sw_data = '0;
    logic        mem_stall, out_valid, RegWrite_out, mem_to_reg_out, ret_future_out, HALT_out, mem_err;
    logic [3:0]  reg_rd_out;
    logic [15:0] alu_result_out, mem_data_out;

    int total = 0;
    int bad = 0;

    mem_if bus ();

    mem_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .RegWrite_in    (RegWrite_in),
        .MemWrite_in    (MemWrite_in),
        .MemRead_in     (MemRead_in),
        .mem_to_reg_in  (mem_to_reg_in),
        .ret_future_in  (ret_future_in),
        .HALT_in        (HALT_in),
        .reg_rd_in      (reg_rd_in),
        .alu_result     (alu_result),
        .sw_data        (sw_data),
        .mem_stall      (mem_stall),
        .dmem           (bus),
        .out_valid      (out_valid),
        .RegWrite_out   (RegWrite_out),
        .mem_to_reg_out (mem_to_reg_out),
        .ret_future_out (ret_future_out),
        .HALT_out       (HALT_out),
        .reg_rd_out     (reg_rd_out),
        .alu_result_out (alu_result_out),
        .mem_data_out   (mem_data_out),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    // Presents one instruction for a single cycle; returns at the negedge after the accept edge.
    task automatic drive_instr(input logic rw, input logic mw, input logic mr, input logic m2r,
                               input logic ret, input logic halt, input logic [3:0] rd,
                               input logic [15:0] alu, input logic [15:0] sw);
        RegWrite_in = rw; MemWrite_in = mw; MemRead_in = mr; mem_to_reg_in = m2r;
        ret_future_in = ret; HALT_in = halt; reg_rd_in = rd; alu_result = alu; sw_data = sw;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        RegWrite_in = 1'b0; MemWrite_in = 1'b0; MemRead_in = 1'b0; mem_to_reg_in = 1'b0;
        ret_future_in = 1'b0; HALT_in = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        total++; if (HALT_out !== 1'b0) begin bad++; $display("FAIL rst_halt: got %b want 0", HALT_out); end
        total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL rst_mem_err: got %b want 0", mem_err); end
        total++; if (mem_data_out !== 16'h0000) begin bad++; $display("FAIL rst_mem_data: got %h want 0000", mem_data_out); end
        total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", bus.dmem_req); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b want 0", mem_stall); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_op();
        drive_instr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 16'h1234, 16'h0000);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL alu_valid: got %b want 1", out_valid); end
        total++; if (alu_result_out !== 16'h1234) begin bad++; $display("FAIL alu_result: got %h want 1234", alu_result_out); end
        total++; if (reg_rd_out !== 4'h3) begin bad++; $display("FAIL alu_rd: got %h want 3", reg_rd_out); end
        total++; if (RegWrite_out !== 1'b1) begin bad++; $display("FAIL alu_regwrite: got %b want 1", RegWrite_out); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL alu_stall: got %b want 0", mem_stall); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL alu_pulse_len: got %b want 0", out_valid); end
        total++; if (alu_result_out !== 16'h1234) begin bad++; $display("FAIL alu_hold: got %h want 1234", alu_result_out); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL alu_stall2: got %b want 0", mem_stall); end
    endtask

    task automatic test_read();
        int stall_cycles = 0;
        drive_instr(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 16'h0040, 16'h0000);
        total++; if (bus.dmem_addr !== 16'h0040) begin bad++; $display("FAIL rd_addr: got %h want 0040", bus.dmem_addr); end
        total++; if (bus.dmem_we !== 1'b0) begin bad++; $display("FAIL rd_we: got %b want 0", bus.dmem_we); end
        for (int i = 0; i < 4; i++) begin
            if (mem_stall === 1'b1) stall_cycles++;
            total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("FAIL rd_req[%0d]: got %b want 1", i, bus.dmem_req); end
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rd_early_valid[%0d]: got %b want 0", i, out_valid); end
            if (i == 3) begin
                bus.dmem_ack = 1'b1;
                bus.dmem_rdata = 16'hBEEF;
            end
            @(negedge clk);
        end
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = 16'h0000;
        total++; if (stall_cycles != 4) begin bad++; $display("FAIL rd_stall_cycles: got %0d want 4", stall_cycles); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rd_valid: got %b want 1", out_valid); end
        total++; if (mem_data_out !== 16'hBEEF) begin bad++; $display("FAIL rd_data: got %h want beef", mem_data_out); end
        total++; if (mem_to_reg_out !== 1'b1) begin bad++; $display("FAIL rd_m2r: got %b want 1", mem_to_reg_out); end
        total++; if (reg_rd_out !== 4'h5) begin bad++; $display("FAIL rd_rd: got %h want 5", reg_rd_out); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rd_stall_end: got %b want 0", mem_stall); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rd_pulse_len: got %b want 0", out_valid); end
    endtask

    task automatic test_write();
        // Stray ack while idle must not retire anything.
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_ack_valid: got %b want 0", out_valid); end
        drive_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0010, 16'hA5A5);
        total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("FAIL wr_req: got %b want 1", bus.dmem_req); end
        total++; if (bus.dmem_we !== 1'b1) begin bad++; $display("FAIL wr_we: got %b want 1", bus.dmem_we); end
        total++; if (bus.dmem_addr !== 16'h0010) begin bad++; $display("FAIL wr_addr: got %h want 0010", bus.dmem_addr); end
        total++; if (bus.dmem_wdata !== 16'hA5A5) begin bad++; $display("FAIL wr_wdata: got %h want a5a5", bus.dmem_wdata); end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 16'h1357;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wr_valid: got %b want 1", out_valid); end
        total++; if (mem_data_out !== 16'hBEEF) begin bad++; $display("FAIL wr_data_kept: got %h want beef", mem_data_out); end
        total++; if (ret_future_out !== 1'b1) begin bad++; $display("FAIL wr_ret: got %b want 1", ret_future_out); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL wr_pulse_len: got %b want 0", out_valid); end
    endtask

    task automatic test_rw_both();
        drive_instr(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h7, 16'h0020, 16'h1111);
        total++; if (bus.dmem_we !== 1'b1) begin bad++; $display("FAIL rw_we: got %b want 1", bus.dmem_we); end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 16'hDEAD;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rw_valid: got %b want 1", out_valid); end
        total++; if (mem_data_out !== 16'hBEEF) begin bad++; $display("FAIL rw_data_kept: got %h want beef", mem_data_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        drive_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 16'h0080, 16'h0000);
        total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("FAIL rm_req_before: got %b want 1", bus.dmem_req); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL rm_req_now: got %b want 0", bus.dmem_req); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL rm_stall: got %b want 0", mem_stall); end
        total++; if (mem_data_out !== 16'h0000) begin bad++; $display("FAIL rm_data_clr: got %h want 0000", mem_data_out); end
        bus.dmem_ack = 1'b1;
        bus.dmem_rdata = 16'h4444;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rm_late_ack_valid: got %b want 0", out_valid); end
        total++; if (mem_data_out !== 16'h0000) begin bad++; $display("FAIL rm_late_ack_data: got %h want 0000", mem_data_out); end
        bus.dmem_ack = 1'b0;
        @(negedge clk);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        drive_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h9, 16'h0100, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus.dmem_ack = 1'b1;
                bus.dmem_rdata = 16'h2222;
            end
            @(negedge clk);
        end
        bus.dmem_ack = 1'b0;
        total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL to_ack_edge_err: got %b want 0", mem_err); end
        total++; if (RegWrite_out !== 1'b1) begin bad++; $display("FAIL to_ack_edge_rw: got %b want 1", RegWrite_out); end
        total++; if (mem_data_out !== 16'h2222) begin bad++; $display("FAIL to_ack_edge_data: got %h want 2222", mem_data_out); end
        @(negedge clk);
        drive_instr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 16'h0200, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.dmem_req !== 1'b1) begin bad++; $display("FAIL to_req[%0d]: got %b want 1", i, bus.dmem_req); end
            @(negedge clk);
        end
        total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL to_req_drop: got %b want 0", bus.dmem_req); end
        total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", mem_err); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL to_valid: got %b want 1", out_valid); end
        total++; if (RegWrite_out !== 1'b0) begin bad++; $display("FAIL to_rw: got %b want 0", RegWrite_out); end
        @(negedge clk);
        total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky: got %b want 1", mem_err); end
        total++; if (mem_stall !== 1'b0) begin bad++; $display("FAIL to_idle: got %b want 0", mem_stall); end
    endtask
`endif

    task automatic test_halt_after_access();
        do_reset();
        drive_instr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 16'h0300, 16'h5A5A);
        total++; if (HALT_out !== 1'b0) begin bad++; $display("FAIL ha_early_halt: got %b want 0", HALT_out); end
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ha_valid: got %b want 1", out_valid); end
        total++; if (HALT_out !== 1'b1) begin bad++; $display("FAIL ha_halt: got %b want 1", HALT_out); end
        total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL ha_stall: got %b want 1", mem_stall); end
        total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL ha_req: got %b want 0", bus.dmem_req); end
    endtask

    task automatic test_halt();
        do_reset();
        total++; if (HALT_out !== 1'b0) begin bad++; $display("FAIL h_reset_clear: got %b want 0", HALT_out); end
        drive_instr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 16'h0BAD, 16'h0000);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL h_valid: got %b want 1", out_valid); end
        total++; if (HALT_out !== 1'b1) begin bad++; $display("FAIL h_halt: got %b want 1", HALT_out); end
        RegWrite_in = 1'b1; MemRead_in = 1'b1; alu_result = 16'h5555; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL h_ignored_valid[%0d]: got %b want 0", i, out_valid); end
            total++; if (mem_stall !== 1'b1) begin bad++; $display("FAIL h_stall[%0d]: got %b want 1", i, mem_stall); end
            total++; if (HALT_out !== 1'b1) begin bad++; $display("FAIL h_hold[%0d]: got %b want 1", i, HALT_out); end
        end
        total++; if (alu_result_out !== 16'h0BAD) begin bad++; $display("FAIL h_alu_hold: got %h want 0bad", alu_result_out); end
        total++; if (bus.dmem_req !== 1'b0) begin bad++; $display("FAIL h_no_req: got %b want 0", bus.dmem_req); end
        in_valid = 1'b0; RegWrite_in = 1'b0; MemRead_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_alu_op();
        test_read();
        test_write();
        test_rw_both();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_halt_after_access();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum cycles spent waiting for dmem_ack.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 in_valid  in  1  EX stage presents an instruction.
REQ-004 RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in, ret_future_in, HALT_in  in  1 each  EX control passthroughs.
REQ-005 reg_rd_in  in  4  destination register; alu_result  in  16  ALU result / memory address; sw_data  in  16  store data.
REQ-006 mem_stall  out  1  back-pressure to EX, which holds its outputs while this is high.
REQ-007 dmem_req, dmem_we  out  1 each; dmem_addr, dmem_wdata  out  16 each; dmem_rdata  in  16; dmem_ack  in  1.
REQ-008 out_valid, RegWrite_out, mem_to_reg_out, ret_future_out, HALT_out  out  1 each; reg_rd_out  out  4; alu_result_out, mem_data_out  out  16 each; mem_err  out  1.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, HALTED.
REQ-010 mem_stall SHALL equal (state != IDLE), combinationally.
REQ-011 In IDLE with in_valid=1, the block SHALL capture all inputs into holding registers on the rising edge.
REQ-012 If the captured instruction has MemRead_in or MemWrite_in set, the next state SHALL be ACCESS; otherwise the state SHALL remain IDLE and out_valid SHALL pulse on the next cycle (latency 1).
REQ-013 In ACCESS, dmem_req SHALL be 1 and dmem_addr/dmem_wdata SHALL come from the held alu_result/sw_data.
REQ-014 dmem_we SHALL be MemWrite; when both MemRead and MemWrite are set, the access SHALL be a write.
REQ-015 dmem_ack SHALL be ignored while dmem_req=0.
REQ-016 On dmem_ack in ACCESS, a read SHALL capture dmem_rdata into mem_data_out; the FSM SHALL return to IDLE, and out_valid SHALL pulse 1 cycle after the ack.
REQ-017 Memory-op latency SHALL be: accept at t, req from t+1, ack at t+1+w, out_valid at t+2+w.
REQ-018 out_valid SHALL be high for exactly one cycle per accepted instruction.
REQ-019 Output fields SHALL hold their values until the next out_valid.
REQ-020 mem_data_out SHALL be unchanged by non-read instructions.
REQ-021 An accepted HALT_in=1 SHALL enter HALTED after any pending access completes, and SHALL produce its out_valid pulse with HALT_out=1.
REQ-022 HALT_out SHALL stay high and in_valid SHALL be ignored until reset.
REQ-023 dmem_addr SHALL pass 16 bits unmodified; there SHALL be no alignment check or address wrap logic.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE and dmem_req=0.
REQ-025 rst_n=0 SHALL clear every output and holding register to 0, including out_valid, HALT_out, mem_err and mem_data_out.
REQ-026 Reset asserted mid-ACCESS SHALL abandon the access without an out_valid pulse; a late dmem_ack after reset SHALL be ignored.

Configuration
REQ-027 With macro MEM_TIMEOUT_EN defined, a cycle counter SHALL count ACCESS cycles.
REQ-028 With MEM_TIMEOUT_EN, reaching TIMEOUT_CYCLES without an ack SHALL drop dmem_req and set mem_err sticky until reset.
REQ-029 With MEM_TIMEOUT_EN, a timeout SHALL pulse out_valid with RegWrite_out=0 and return to IDLE.
REQ-030 With MEM_TIMEOUT_EN, an ack in the same cycle the limit is reached SHALL win over the timeout.
REQ-031 Without MEM_TIMEOUT_EN, ACCESS SHALL wait indefinitely, no counter SHALL exist, and mem_err SHALL be tied to 0.

Structure
REQ-032 Package mem_pkg SHALL hold the mem_state_t enum (IDLE, ACCESS, HALTED) and the default TIMEOUT_CYCLES constant.
REQ-033 Sub-module mem_timeout_ctr (clear, enable, expired) SHALL be instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-034 Non-memory op, alu_result=16'h1234, reg_rd_in=4'h3, RegWrite_in=1 -> out_valid one cycle later, alu_result_out=16'h1234, mem_stall never high.
REQ-035 Read addr 16'h0040, ack after 3 cycles with rdata=16'hBEEF -> mem_stall high 4 cycles, mem_data_out=16'hBEEF, out_valid 1 cycle after ack.
REQ-036 Write addr 16'h0010, sw_data=16'hA5A5, immediate ack -> dmem_we=1, dmem_wdata=16'hA5A5, single out_valid pulse, mem_data_out unchanged.
REQ-037 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> dmem_req drops after 4 cycles, mem_err=1, RegWrite_out=0; ack arriving on cycle 4 -> no error.
REQ-038 rst_n pulsed low mid-ACCESS -> dmem_req=0 at once, no out_valid; HALT_in accepted -> HALT_out=1, mem_stall stays high, later in_valid ignored.
